// File: rtl/y_arith.sv
// 32-bit ripple-carry adder/subtractor with combinational result/carry/overflow
// and a registered copy of the result and status flags.
module y_arith #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] z_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             zero_q,
    output logic             neg_q,
    output logic             out_valid
);

    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             c_msb;
    logic             c_top;

    // cin doubles as the subtract select: a - b = a + ~b + 1.
    always_comb begin
        bb    = '0;
        sum   = '0;
        carry = cin;
        c_msb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            bb[i] = cin ? ~b[i] : b[i];
            if (i == WIDTH - 1) begin
                c_msb = carry;
            end
            sum[i] = a[i] ^ bb[i] ^ carry;
            carry  = (a[i] & bb[i]) | (carry & (a[i] ^ bb[i]));
        end
        c_top = carry;
    end

    assign z    = sum;
    assign cout = c_top;
    assign ovf  = c_msb ^ c_top;

    logic zero_d;
    logic neg_d;

    assign zero_d = (sum == '0);
    assign neg_d  = sum[WIDTH-1];

    // in_valid qualifies capture of a/b/cin; out_valid marks the registered
    // copy as fresh for exactly one cycle. There is no backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q       <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                z_q    <= sum;
                cout_q <= c_top;
                ovf_q  <= c_msb ^ c_top;
                zero_q <= zero_d;
                neg_q  <= neg_d;
            end
        end
    end

endmodule

// File: tb/tb_y_arith.sv
// Directed and random checks of the y_arith adder/subtractor and its register stage.
module tb_y_arith;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        in_valid;
    logic [31:0] z;
    logic        cout;
    logic        ovf;
    logic [31:0] z_q;
    logic        cout_q;
    logic        ovf_q;
    logic        zero_q;
    logic        neg_q;
    logic        out_valid;

    int n_assert;
    int n_fail;

    y_arith #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .z         (z),
        .cout      (cout),
        .ovf       (ovf),
        .z_q       (z_q),
        .cout_q    (cout_q),
        .ovf_q     (ovf_q),
        .zero_q    (zero_q),
        .neg_q     (neg_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                         input logic tv);
        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = tv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra, rb, exp_z;
        logic        rc, exp_ovf;
        logic [32:0] s33;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        apply(32'd0, 32'd0, 1'b0, 1'b0);

        check("rst z_q", z_q, 32'd0);
        check("rst cout_q", {31'd0, cout_q}, 32'd0);
        check("rst ovf_q", {31'd0, ovf_q}, 32'd0);
        check("rst zero_q", {31'd0, zero_q}, 32'd0);
        check("rst neg_q", {31'd0, neg_q}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        apply(32'd5, 32'd3, 1'b0, 1'b1);
        check("add z", z, 32'd8);
        check("add cout", {31'd0, cout}, 32'd0);
        check("add ovf", {31'd0, ovf}, 32'd0);
        tick();
        check("add z_q", z_q, 32'd8);
        check("add out_valid", {31'd0, out_valid}, 32'd1);
        check("add zero_q", {31'd0, zero_q}, 32'd0);
        check("add neg_q", {31'd0, neg_q}, 32'd0);

        apply(32'd5, 32'd3, 1'b1, 1'b1);
        check("sub z", z, 32'd2);
        check("sub cout", {31'd0, cout}, 32'd1);
        check("sub ovf", {31'd0, ovf}, 32'd0);
        tick();
        check("sub cout_q", {31'd0, cout_q}, 32'd1);

        apply(32'd3, 32'd5, 1'b1, 1'b1);
        check("borrow z", z, 32'hFFFF_FFFE);
        check("borrow cout", {31'd0, cout}, 32'd0);
        tick();
        check("borrow neg_q", {31'd0, neg_q}, 32'd1);
        check("borrow cout_q", {31'd0, cout_q}, 32'd0);

        apply(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        check("wrap z", z, 32'd0);
        check("wrap cout", {31'd0, cout}, 32'd1);
        check("wrap ovf", {31'd0, ovf}, 32'd0);
        tick();
        check("wrap zero_q", {31'd0, zero_q}, 32'd1);
        check("wrap cout_q", {31'd0, cout_q}, 32'd1);
        check("wrap neg_q", {31'd0, neg_q}, 32'd0);

        apply(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        check("povf z", z, 32'h8000_0000);
        check("povf ovf", {31'd0, ovf}, 32'd1);
        check("povf cout", {31'd0, cout}, 32'd0);
        tick();
        check("povf ovf_q", {31'd0, ovf_q}, 32'd1);
        check("povf neg_q", {31'd0, neg_q}, 32'd1);

        apply(32'h8000_0000, 32'd1, 1'b1, 1'b0);
        check("novf z", z, 32'h7FFF_FFFF);
        check("novf ovf", {31'd0, ovf}, 32'd1);
        check("novf cout", {31'd0, cout}, 32'd1);

        apply(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
        check("a_eq_b z", z, 32'd0);
        check("a_eq_b cout", {31'd0, cout}, 32'd1);
        apply(32'd0, 32'd0, 1'b1, 1'b0);
        check("zero_sub z", z, 32'd0);
        check("zero_sub cout", {31'd0, cout}, 32'd1);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            apply(ra, rb, rc, 1'b0);
            exp_z   = rc ? (ra - rb) : (ra + rb);
            s33     = {1'b0, ra} + {1'b0, (rc ? ~rb : rb)} + {32'd0, rc};
            exp_ovf = rc ? ((ra[31] != rb[31]) && (exp_z[31] != ra[31]))
                         : ((ra[31] == rb[31]) && (exp_z[31] != ra[31]));
            check("rand z", z, exp_z);
            check("rand cout", {31'd0, cout}, {31'd0, s33[32]});
            check("rand ovf", {31'd0, ovf}, {31'd0, exp_ovf});
        end

        apply(32'd5, 32'd3, 1'b0, 1'b1);
        tick();
        check("pre-reset z_q", z_q, 32'd8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async z_q", z_q, 32'd0);
        check("async out_valid", {31'd0, out_valid}, 32'd0);
        check("async cout_q", {31'd0, cout_q}, 32'd0);
        check("async zero_q", {31'd0, zero_q}, 32'd0);
        check("async neg_q", {31'd0, neg_q}, 32'd0);
        check("async ovf_q", {31'd0, ovf_q}, 32'd0);
        check("async comb z", z, 32'd8);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("post-reset out_valid", {31'd0, out_valid}, 32'd0);
        check("post-reset z_q", z_q, 32'd0);

        apply(32'd10, 32'd4, 1'b1, 1'b1);
        tick();
        check("hold load z_q", z_q, 32'd6);
        check("hold load out_valid", {31'd0, out_valid}, 32'd1);
        apply(32'd100, 32'd1, 1'b1, 1'b0);
        check("hold comb z", z, 32'd99);
        tick();
        check("hold z_q", z_q, 32'd6);
        check("hold out_valid", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/y_arith.md
Name: y_arith

Overview:
- 32-bit adder/subtractor for the datapath ALU.
- A single control bit selects the operation: cin=0 computes a+b, cin=1 computes a-b.
- The result and carry are combinational, so they are valid within the same simulation step.
- A registered copy of the result, carry and status flags is also provided for pipelined consumers.

Parameters:
- WIDTH, 32, operand/result width. Behaviour is specified for 32; other values are not required to be supported.

Ports:
- clk  input  1  clock; registered outputs update on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all registered outputs.
- a  input  32  operand A.
- b  input  32  operand B.
- cin  input  1  operation select and carry-in: 0 = add, 1 = subtract.
- in_valid  input  1  qualifies a/b/cin for capture into the output register.
- z  output  32  combinational result, modulo 2^32.
- cout  output  1  combinational carry out of bit 31.
- ovf  output  1  combinational signed-overflow flag.
- z_q  output  32  registered z.
- cout_q  output  1  registered cout.
- ovf_q  output  1  registered ovf.
- zero_q  output  1  registered (z == 0).
- neg_q  output  1  registered z[31].
- out_valid  output  1  registered in_valid, giving one-cycle latency.

Behaviour:
- Combinational path, with no clock involvement:
  - bb = cin ? ~b : b.
  - {cout, z} = a + bb + cin, using a 33-bit sum.
  - In effect, z = a+b when cin=0 and z = a-b when cin=1, both mod 2^32.
- The adder is a 32-stage ripple chain of 1-bit full adders:
  - Stage 0 carry-in is cin.
  - Each stage i computes s_i = a_i ^ bb_i ^ c_i and c_{i+1} = a_i&bb_i | c_i&(a_i^bb_i).
  - cout = c_32.
- The operand-B inversion is a per-bit 2:1 mux selected by cin.
- Carry semantics:
  - Add: cout = 1 on unsigned overflow.
  - Subtract: cout = 1 means no borrow (a >= b unsigned); cout = 0 means borrow.
- ovf = c_31 ^ c_32, i.e. a signed two's-complement overflow for the selected operation.
- z and cout do not depend on signedness: the signed and unsigned interpretations give identical bits.
- Outputs settle within one simulation step of an input change. They contain no latches and must be free of X when the inputs are known.
- Registered path:
  - On posedge clk with rst_n=1: z_q<=z, cout_q<=cout, ovf_q<=ovf, zero_q<=(z==0), neg_q<=z[31], out_valid<=in_valid.
  - The data registers load only when in_valid=1; when in_valid=0 they hold their previous values.
  - out_valid always loads in_valid.
- Reset:
  - rst_n=0 immediately, without waiting for a clock, forces z_q=0, cout_q=0, ovf_q=0, zero_q=0, neg_q=0, out_valid=0.
  - Deassertion is sampled at the next rising edge.
  - Reset asserted mid-operation discards the in-flight result.
  - Reset has no effect on the combinational z, cout and ovf.
- Boundary cases:
  - a=b with cin=1 gives z=0 and cout=1.
  - 0-0 with cin=1 gives z=0 and cout=1.
  - 0xFFFFFFFF+1 wraps to 0 with cout=1.

Test Plan:
- Add without carry: a=5, b=3, cin=0 -> z=8, cout=0, ovf=0; after one edge with in_valid=1, z_q=8, out_valid=1.
- Subtract and borrow:
  - a=5, b=3, cin=1 -> z=2, cout=1.
  - a=3, b=5, cin=1 -> z=0xFFFFFFFE, cout=0; after the edge, neg_q=1.
- Wrap and overflow:
  - a=0xFFFFFFFF, b=1, cin=0 -> z=0, cout=1, ovf=0; after the edge, zero_q=1.
  - a=0x7FFFFFFF, b=1, cin=0 -> z=0x80000000, ovf=1.
  - a=0x80000000, b=1, cin=1 -> z=0x7FFFFFFF, ovf=1.
- Random sweep: 1000 random {a, b, cin}, checking 1 time unit after each apply -> z equals (a+b) or (a-b) mod 2^32, and cout equals bit 32 of a + bb + cin.
- Async reset: load z_q=8, then drop rst_n between edges -> all registered outputs go to 0 immediately while the combinational z stays 8. Raise rst_n and hold in_valid=0 for one edge -> out_valid=0 and z_q stays 0.
- Hold: apply in_valid=1 with a=10, b=4, cin=1, then in_valid=0 with new operands -> z_q stays 6 and out_valid drops to 0.
